regfile_wb_queue: RTL and testbench

//   Write-side front end of the 16x32 register file. Buffers register writebacks from three

---
 rtl/regfile_wb_queue_if.sv | 45 ++++
 rtl/regfile_wb_queue.sv | 112 +++++++++++
 tb/tb_regfile_wb_queue.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Writeback bus between the three producers, the drain control and the regfile
// write ports. The queue sits on the slave side; producers and drain control sit on the master side.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ch0_valid, ch1_valid, ch2_valid;
    logic          ch0_ready, ch1_ready, ch2_ready;
    logic [AW-1:0] ch0_addr, ch1_addr, ch2_addr;
    logic [DW-1:0] ch0_data, ch1_data, ch2_data;
    logic          drain_en;
    logic [AW-1:0] w_addr1, w_addr2, w_addr3;
    logic [DW-1:0] w_data1, w_data2, w_data3;
    logic          w_en1, w_en2, w_en3;
    logic [(1<<AW)-1:0] pending;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output ch0_valid, ch1_valid, ch2_valid,
        output ch0_addr, ch1_addr, ch2_addr,
        output ch0_data, ch1_data, ch2_data,
        output drain_en,
        input  ch0_ready, ch1_ready, ch2_ready,
        input  w_addr1, w_addr2, w_addr3,
        input  w_data1, w_data2, w_data3,
        input  w_en1, w_en2, w_en3,
        input  pending, count, empty
    );

    modport slave (
        input  ch0_valid, ch1_valid, ch2_valid,
        input  ch0_addr, ch1_addr, ch2_addr,
        input  ch0_data, ch1_data, ch2_data,
        input  drain_en,
        output ch0_ready, ch1_ready, ch2_ready,
        output w_addr1, w_addr2, w_addr3,
        output w_data1, w_data2, w_data3,
        output w_en1, w_en2, w_en3,
        output pending, count, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue: up to three enqueues and three drains per cycle;
// oldest drained entry goes to port 1 so the regfile's port-3 priority keeps the youngest.
module regfile_wb_queue #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic          ready;
    logic [2:0]    ch_v;
    logic [AW-1:0] ch_a [3];
    logic [DW-1:0] ch_w [3];
    logic [1:0]    n_drain, n_acc;
    logic [PW-1:0] slot;
    logic [PW-1:0] off;
    logic [NR-1:0] pending_v;

    // Three free slots are always kept so a full three-channel burst can never overflow.
    assign ready = !rst && (count_q <= CW'(DEPTH - 3));

    assign ch_v    = {bus.ch2_valid, bus.ch1_valid, bus.ch0_valid};
    assign ch_a[0] = bus.ch0_addr;
    assign ch_a[1] = bus.ch1_addr;
    assign ch_a[2] = bus.ch2_addr;
    assign ch_w[0] = bus.ch0_data;
    assign ch_w[1] = bus.ch1_data;
    assign ch_w[2] = bus.ch2_data;

    always_comb begin
        n_drain = 2'd0;
        if (bus.drain_en)
            n_drain = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        slot   = tail_q;
        n_acc  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (ch_v[i] && ready) begin
                addr_d[slot] = ch_a[i];
                data_d[slot] = ch_w[i];
                slot         = slot + PW'(1);
                n_acc        = n_acc + 2'd1;
            end
        end
        tail_d  = slot;
        head_d  = head_q + PW'(n_drain);
        count_d = count_q + CW'(n_acc) - CW'(n_drain);
    end

    // Occupancy is derived from head/count, so entries need no per-slot valid bit.
    always_comb begin
        pending_v = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if (CW'(off) < count_q)
                pending_v[addr_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign bus.ch0_ready = ready;
    assign bus.ch1_ready = ready;
    assign bus.ch2_ready = ready;

    assign bus.w_en1   = (n_drain >= 2'd1);
    assign bus.w_en2   = (n_drain >= 2'd2);
    assign bus.w_en3   = (n_drain == 2'd3);
    assign bus.w_addr1 = addr_q[head_q];
    assign bus.w_addr2 = addr_q[head_q + PW'(1)];
    assign bus.w_addr3 = addr_q[head_q + PW'(2)];
    assign bus.w_data1 = data_q[head_q];
    assign bus.w_data2 = data_q[head_q + PW'(1)];
    assign bus.w_data3 = data_q[head_q + PW'(2)];

    assign bus.pending = pending_v;
    assign bus.count   = count_q;
    assign bus.empty   = (count_q == '0);
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and random stimulus against a queue-based reference model plus a
// model regfile that applies drained writes in issue order.
module tb_regfile_wb_queue;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();
    regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    ent_t mq[$];
    logic [DW-1:0] gold_rf [16];
    logic [DW-1:0] dut_rf  [16];

    // Regfile fed by the DUT's write ports; later ports win on the same address.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.w_en1) dut_rf[bus.w_addr1] <= bus.w_data1;
            if (bus.w_en2) dut_rf[bus.w_addr2] <= bus.w_data2;
            if (bus.w_en3) dut_rf[bus.w_addr3] <= bus.w_data3;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setch(input int n, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (n)
            0: begin bus.ch0_valid = v; bus.ch0_addr = a; bus.ch0_data = d; end
            1: begin bus.ch1_valid = v; bus.ch1_addr = a; bus.ch1_data = d; end
            default: begin bus.ch2_valid = v; bus.ch2_addr = a; bus.ch2_data = d; end
        endcase
    endtask

    task automatic idle_ch();
        for (int n = 0; n < 3; n++) setch(n, 1'b0, '0, '0);
    endtask

    // Check the current cycle against the model, then advance both across one edge.
    task automatic cyc();
        int dd;
        bit rdy;
        logic [15:0] pm;
        ent_t e;
        #1;
        rdy = (mq.size() <= DEPTH - 3);
        dd  = bus.drain_en ? ((mq.size() < 3) ? mq.size() : 3) : 0;
        pm  = '0;
        foreach (mq[i]) pm[mq[i].a] = 1'b1;
        chk("ready0", bus.ch0_ready, rdy);
        chk("ready1", bus.ch1_ready, rdy);
        chk("ready2", bus.ch2_ready, rdy);
        chk("count", bus.count, mq.size());
        chk("empty", bus.empty, mq.size() == 0);
        chk("pending", bus.pending, pm);
        chk("w_en1", bus.w_en1, dd >= 1);
        chk("w_en2", bus.w_en2, dd >= 2);
        chk("w_en3", bus.w_en3, dd >= 3);
        if (dd >= 1) begin chk("w_addr1", bus.w_addr1, mq[0].a); chk("w_data1", bus.w_data1, mq[0].d); end
        if (dd >= 2) begin chk("w_addr2", bus.w_addr2, mq[1].a); chk("w_data2", bus.w_data2, mq[1].d); end
        if (dd >= 3) begin chk("w_addr3", bus.w_addr3, mq[2].a); chk("w_data3", bus.w_data3, mq[2].d); end
        @(posedge clk);
        for (int k = 0; k < dd; k++) begin
            e = mq.pop_front();
            gold_rf[e.a] = e.d;
        end
        if (rdy) begin
            if (bus.ch0_valid) mq.push_back('{a: bus.ch0_addr, d: bus.ch0_data});
            if (bus.ch1_valid) mq.push_back('{a: bus.ch1_addr, d: bus.ch1_data});
            if (bus.ch2_valid) mq.push_back('{a: bus.ch2_addr, d: bus.ch2_data});
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin gold_rf[r] = '0; dut_rf[r] = '0; end
        rst = 1'b1;
        bus.drain_en = 1'b1;
        for (int n = 0; n < 3; n++) setch(n, 1'b1, AW'(n), DW'(n));
        @(negedge clk);
        chk("rst_ready", bus.ch0_ready, 1'b0);
        chk("rst_wen", {bus.w_en1, bus.w_en2, bus.w_en3}, 3'b000);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_pending", bus.pending, 16'h0);
        rst = 1'b0;
        idle_ch();

        // Single write, drained the following cycle.
        setch(0, 1'b1, 4'd3, 32'hDEADBEEF);
        cyc();
        idle_ch();
        #1;
        chk("t1_wen1", bus.w_en1, 1'b1);
        chk("t1_addr1", bus.w_addr1, 4'd3);
        chk("t1_data1", bus.w_data1, 32'hDEADBEEF);
        chk("t1_pend3", bus.pending[3], 1'b1);
        cyc();
        cyc();

        // Three same-address writes in one cycle: youngest must survive.
        setch(0, 1'b1, 4'd5, 32'd1);
        setch(1, 1'b1, 4'd5, 32'd2);
        setch(2, 1'b1, 4'd5, 32'd3);
        cyc();
        idle_ch();
        cyc();
        cyc();
        chk("t2_r5", dut_rf[5], 32'd3);

        // Fill with draining off until ready drops, hold a valid, then drain.
        bus.drain_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int n = 0; n < 3; n++) setch(n, 1'b1, AW'(c * 3 + n), DW'(32'h100 + c * 3 + n));
            cyc();
        end
        chk("t3_count", bus.count, 6);
        idle_ch();
        bus.drain_en = 1'b1;
        for (int c = 0; c < 3; c++) cyc();

        // Wrap-around with drain toggling every two cycles.
        for (int i = 0; i < 20; i++) begin
            bus.drain_en = ((i / 2) % 2) == 1;
            setch(0, 1'b1, AW'(i % 16), DW'(i));
            cyc();
        end
        idle_ch();
        bus.drain_en = 1'b1;
        for (int c = 0; c < 4; c++) cyc();

        // Reset with entries queued: everything dropped, regfile untouched.
        bus.drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setch(0, 1'b1, AW'(i + 8), DW'(32'hA000 + i));
            cyc();
        end
        idle_ch();
        chk("t5_count_pre", bus.count, 5);
        bus.drain_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_ready", bus.ch0_ready, 1'b0);
        chk("t5_wen", {bus.w_en1, bus.w_en2, bus.w_en3}, 3'b000);
        chk("t5_count", bus.count, 0);
        chk("t5_pending", bus.pending, 16'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        for (int r = 0; r < 16; r++) chk("t5_rf", dut_rf[r], gold_rf[r]);

        // Simultaneous drain of three and enqueue of two.
        bus.drain_en = 1'b0;
        for (int n = 0; n < 3; n++) setch(n, 1'b1, AW'(n), DW'(32'hB0 + n));
        cyc();
        idle_ch();
        bus.drain_en = 1'b1;
        setch(0, 1'b1, 4'd9, 32'hC0);
        setch(1, 1'b1, 4'd10, 32'hC1);
        cyc();
        idle_ch();
        chk("t6_count", bus.count, 2);
        cyc();
        cyc();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            bus.drain_en = ($urandom_range(0, 99) < 50);
            for (int n = 0; n < 3; n++)
                setch(n, $urandom_range(0, 99) < 60, AW'($urandom_range(0, 15)), DW'($urandom));
            cyc();
        end
        idle_ch();
        bus.drain_en = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        for (int r = 0; r < 16; r++) chk("final_rf", dut_rf[r], gold_rf[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
